// File: rtl/cfi_shadow_stack_ctrl.sv
// ============================================================================
// Module   : cfi_shadow_stack_ctrl
// Brief    : Commit-side CFI shadow-stack sequencer (push/popchk/load/inc/wrssp).
//            Define CFI_SS_BOUNDS_CHECK_EN to add ss_base_i/ss_limit_i checks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cfi_shadow_stack_ctrl #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] SSP_RESET = '0,
    parameter int unsigned     INC_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [XLEN-1:0]  cmd_data_i,
    input  logic [INC_W-1:0] cmd_cnt_i,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    output logic             rsp_valid_o,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic             rsp_fault_o,
    output logic [XLEN-1:0]  ssp_o
`ifdef CFI_SS_BOUNDS_CHECK_EN
    ,
    input  logic [XLEN-1:0]  ss_base_i,
    input  logic [XLEN-1:0]  ss_limit_i
`endif
);

    localparam logic [XLEN-1:0] c_STEP     = XLEN'(XLEN / 8);
    localparam logic [2:0]      c_OP_PUSH  = 3'd0;
    localparam logic [2:0]      c_OP_POP   = 3'd1;
    localparam logic [2:0]      c_OP_LOAD  = 3'd2;
    localparam logic [2:0]      c_OP_INC   = 3'd3;
    localparam logic [2:0]      c_OP_WRSSP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_ssp;
    logic [XLEN-1:0] w_ssp_nxt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_fault;
    logic            w_accept;
    logic            w_rsp_ld;
    logic [XLEN-1:0] w_rsp_data_nxt;
    logic            w_rsp_fault_nxt;
    logic [XLEN-1:0] w_cmd_addr;
    logic [XLEN-1:0] w_inc_bytes;
    logic            w_oob;

    // PUSH pre-decrements; pops and loads read at the current ssp.
    assign w_cmd_addr  = (cmd_op_i == c_OP_PUSH) ? (r_ssp - c_STEP) : r_ssp;
    assign w_inc_bytes = XLEN'(cmd_cnt_i) * c_STEP;

`ifdef CFI_SS_BOUNDS_CHECK_EN
    logic [XLEN-1:0] w_lim_hi;
    assign w_lim_hi = ss_base_i - c_STEP;
    assign w_oob    = (w_cmd_addr < ss_limit_i) || (w_cmd_addr > w_lim_hi);
`else
    assign w_oob    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ssp_nxt       = r_ssp;
        w_accept        = 1'b0;
        w_rsp_ld        = 1'b0;
        w_rsp_data_nxt  = '0;
        w_rsp_fault_nxt = 1'b0;
        cmd_ready_o     = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        rsp_valid_o     = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && !flush_i) begin
                    w_accept = 1'b1;
                    case (cmd_op_i)
                        c_OP_PUSH, c_OP_POP, c_OP_LOAD: begin
                            if (w_oob) begin
                                w_state_nxt     = S_RESP;
                                w_rsp_ld        = 1'b1;
                                w_rsp_fault_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_REQ;
                            end
                        end
                        c_OP_INC: begin
                            w_ssp_nxt   = r_ssp + w_inc_bytes;
                            w_state_nxt = S_RESP;
                            w_rsp_ld    = 1'b1;
                        end
                        c_OP_WRSSP: begin
                            w_ssp_nxt   = cmd_data_i;
                            w_state_nxt = S_RESP;
                            w_rsp_ld    = 1'b1;
                        end
                        default: begin
                            w_state_nxt     = S_RESP;
                            w_rsp_ld        = 1'b1;
                            w_rsp_fault_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_REQ: begin
                mem_req_o = 1'b1;
                mem_we_o  = (r_op == c_OP_PUSH);
                if (mem_gnt_i) begin
                    if (r_op == c_OP_PUSH) begin
                        // A flushed store still lands in memory; only ssp and the response are dropped.
                        if (flush_i) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ssp_nxt   = r_addr;
                            w_state_nxt = S_RESP;
                            w_rsp_ld    = 1'b1;
                        end
                    end else begin
                        w_state_nxt = flush_i ? S_DRAIN : S_WAIT_R;
                    end
                end else if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT_R: begin
                if (flush_i) begin
                    w_state_nxt = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    w_state_nxt = S_RESP;
                    w_rsp_ld    = 1'b1;
                    if (r_op == c_OP_LOAD) begin
                        w_rsp_data_nxt = mem_rdata_i;
                        w_ssp_nxt      = r_ssp + c_STEP;
                    end else if (mem_rdata_i == r_data) begin
                        w_ssp_nxt      = r_ssp + c_STEP;
                    end else begin
                        w_rsp_fault_nxt = 1'b1;
                    end
                end
            end

            S_RESP: begin
                rsp_valid_o = !flush_i;
                w_state_nxt = S_IDLE;
            end

            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        rsp_data_o  = rsp_valid_o ? r_rsp_data : '0;
        rsp_fault_o = rsp_valid_o & r_rsp_fault;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ssp       <= SSP_RESET;
            r_op        <= 3'd0;
            r_data      <= '0;
            r_addr      <= '0;
            r_rsp_data  <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_ssp <= w_ssp_nxt;
            if (w_accept) begin
                r_op   <= cmd_op_i;
                r_data <= cmd_data_i;
                r_addr <= w_cmd_addr;
            end
            if (w_rsp_ld) begin
                r_rsp_data  <= w_rsp_data_nxt;
                r_rsp_fault <= w_rsp_fault_nxt;
            end
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_data;
    assign ssp_o       = r_ssp;

endmodule

`default_nettype wire

// File: doc/cfi_shadow_stack_ctrl.md
Name: cfi_shadow_stack_ctrl

Overview:
- Sequences shadow-stack operations issued at commit for the CFI extension: SSPUSH x1/x5, SSPOPCHK x1/x5, SSLOAD x1/x5, SSPINC and shadow-stack-pointer writes.
- Owns the architectural shadow stack pointer (ssp) and turns each command into zero or one data-memory transaction on a dedicated request/grant/rvalid port.
- Compares popped values against the link register and returns a result or a CFI fault to commit.
- Sits between the commit stage and a data-cache port arbiter.

Parameters:
XLEN, 64, data/address width; ssp step is XLEN/8 bytes
SSP_RESET, 64'h0, ssp value after reset
INC_W, 5, width of the SSPINC count field

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  abandon the current command (no response, ssp unchanged)
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  controller is IDLE and can accept a command
cmd_op_i  in  3  0=PUSH 1=POPCHK 2=LOAD 3=INC 4=WRSSP; others illegal
cmd_data_i  in  XLEN  PUSH: value to store; POPCHK: compare value; WRSSP: new ssp
cmd_cnt_i  in  INC_W  INC entry count
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request accepted
mem_we_o  out  1  1=store
mem_addr_o  out  XLEN  byte address
mem_wdata_o  out  XLEN  store data
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  XLEN  load data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_data_o  out  XLEN  LOAD: loaded value; otherwise 0
rsp_fault_o  out  1  CFI fault (qualified by rsp_valid_o)
ssp_o  out  XLEN  current ssp

Behaviour:
- Reset: ssp=SSP_RESET; state IDLE; mem_req_o=0, rsp_valid_o=0, rsp_fault_o=0, rsp_data_o=0, cmd_ready_o=1.
- FSM states: IDLE, REQ, WAIT_R, RESP, DRAIN.
- Command accept: cmd_valid_i && cmd_ready_o. The command, its data and the computed address are latched on accept.
- PUSH:
  - addr = ssp - XLEN/8.
  - IDLE -> REQ: mem_req_o=1, mem_we_o=1, held with stable addr/data until mem_gnt_i.
  - On grant: ssp=addr, then RESP. No rvalid is expected for stores.
- POPCHK and LOAD:
  - addr = ssp. REQ issues a read (mem_we_o=0); on grant go to WAIT_R; on mem_rvalid_i go to RESP.
  - POPCHK match (rdata == data): ssp += XLEN/8, fault=0.
  - POPCHK mismatch: ssp unchanged, fault=1.
  - LOAD: rsp_data_o=rdata, ssp += XLEN/8, fault=0.
- INC: no memory access. IDLE -> RESP; ssp += cnt*(XLEN/8).
- WRSSP: no memory access. IDLE -> RESP; ssp = cmd_data_i.
- Illegal op: IDLE -> RESP with fault=1 and no ssp change.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. cmd_ready_o is 1 only in IDLE.
- Minimum latency, accept to rsp_valid_o:
  - INC/WRSSP: 1 cycle.
  - PUSH: 2 cycles with same-cycle grant.
  - POPCHK/LOAD: 3 cycles with grant in REQ and rvalid in the following cycle.
- ssp arithmetic is modulo 2^XLEN; wrap-around is silent.
- flush_i:
  - In REQ before grant: drop the request, go to IDLE.
  - In WAIT_R, or in REQ on the cycle of a read grant: go to DRAIN and wait for the outstanding mem_rvalid_i, then IDLE. No response, ssp unchanged.
  - flush on a PUSH grant cycle: the store is committed to memory but ssp is not updated and no response is sent.
  - flush in RESP suppresses rsp_valid_o.
  - flush has priority over a simultaneous command accept.
- At most one outstanding memory transaction. mem_rvalid_i outside WAIT_R/DRAIN is ignored.
- Asynchronous reset mid-transaction returns to the reset state immediately. Any pending rvalid after reset is ignored.

Optional Feature:
- Macro: CFI_SS_BOUNDS_CHECK_EN.
- When defined:
  - Adds ports ss_base_i/ss_limit_i (XLEN) and bound PUSH/POPCHK/LOAD addresses to [ss_limit_i, ss_base_i - XLEN/8].
  - An out-of-range address issues no memory request; IDLE -> RESP with fault=1 and ssp unchanged.
  - WRSSP is not checked.
- When undefined: the ports are absent and no bounds check is done.

Test Plan:
- Reset with SSP_RESET=0x1000, PUSH data=0xDEAD, gnt in the same cycle → store to 0xFF8 with wdata 0xDEAD; rsp fault=0; ssp_o=0xFF8.
- After that push, POPCHK data=0xDEAD with rdata=0xDEAD → fault=0, ssp_o=0x1000. Repeat with rdata=0xBEEF → fault=1, ssp_o stays 0xFF8.
- WRSSP 0x2000, then INC cnt=3 → ssp_o=0x2018; each responds exactly 1 cycle after accept, no mem_req_o.
- LOAD with gnt delayed 4 cycles: mem_req_o and addr stay stable until gnt; rsp_data_o=mem_rdata_i; ssp += 8.
- POPCHK, flush_i in WAIT_R, rvalid 2 cycles later → no rsp_valid_o; cmd_ready_o rises only after rvalid; ssp unchanged.
- With CFI_SS_BOUNDS_CHECK_EN, base=0x1000, limit=0xF00, ssp=0xF00, PUSH → no mem_req_o, fault=1, ssp_o=0xF00.
